// File: rtl/spi_cfg_sequencer.sv
// Replays a small table of ADC register-write commands through the PL SPI
// master's status / TX-buffer register interface after a start pulse.
module spi_cfg_sequencer #(
    parameter int TBL_DEPTH      = 32,
    parameter int BYTES_PER_CMD  = 3,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    input  logic [5:0]  i_Num_Cmds,
    input  logic        i_Tbl_We,
    input  logic [4:0]  i_Tbl_Addr,
    input  logic [23:0] i_Tbl_Data,
    output logic [7:0]  o_SPI_StatusReg,
    output logic [7:0]  o_SPI_TxBuffer,
    output logic [7:0]  o_SPI_Cmd_Lim,
    input  logic [7:0]  i_SPI_StatusReg,
    input  logic        i_SPI_StatusRW,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Err,
    output logic [5:0]  o_Cmd_Idx
);
    localparam int AW = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1;
    localparam int BW = $clog2(BYTES_PER_CMD + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [7:0]    ST_NONE  = 8'h00;
    localparam logic [7:0]    ST_RESET = 8'h01;
    localparam logic [7:0]    ST_DATA  = 8'h02;
    localparam logic [7:0]    ST_SEND  = 8'h08;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BYTE_LIM = BW'(BYTES_PER_CMD);

    typedef enum logic [2:0] {
        S_IDLE, S_SPI_RST, S_LOAD, S_SEND, S_WAIT, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t        state;
    logic [23:0]   mem [TBL_DEPTH];
    logic [5:0]    num_cmds;
    logic [BW-1:0] byte_cnt;
    logic [1:0]    rst_cnt;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [5:0]    idx_nxt;
    logic [23:0]   cur_word;
    logic [23:0]   nxt_word;
    logic          frame_done;
    logic          unused_bits;

    assign o_SPI_Cmd_Lim = 8'(BYTES_PER_CMD);
    assign idx_nxt       = o_Cmd_Idx + 6'd1;
    assign cur_word      = mem[o_Cmd_Idx[AW-1:0]];
    assign nxt_word      = mem[idx_nxt[AW-1:0]];
    assign frame_done    = i_SPI_StatusRW && i_SPI_StatusReg[7];
    assign unused_bits   = ^{i_SPI_StatusReg[6:0], idx_nxt};

    // Most significant byte of the command word goes out first.
    function automatic logic [7:0] cmd_byte(input logic [23:0] w, input logic [BW-1:0] b);
        return w[23 - 8*int'(b) -: 8];
    endfunction

    // Table has no reset so a re-trigger after reset replays the same config.
    always_ff @(posedge i_Clk) begin
        if (i_Tbl_We && !o_Busy && (int'(i_Tbl_Addr) < TBL_DEPTH))
            mem[i_Tbl_Addr[AW-1:0]] <= i_Tbl_Data;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state           <= S_IDLE;
            o_SPI_StatusReg <= ST_NONE;
            o_SPI_TxBuffer  <= 8'h00;
            o_Busy          <= 1'b0;
            o_Done          <= 1'b0;
            o_Err           <= 1'b0;
            o_Cmd_Idx       <= 6'd0;
            num_cmds        <= 6'd0;
            byte_cnt        <= '0;
            rst_cnt         <= 2'd0;
            gap_cnt         <= '0;
            tmo_cnt         <= '0;
        end else begin
            o_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        num_cmds  <= (i_Num_Cmds > 6'(TBL_DEPTH)) ? 6'(TBL_DEPTH) : i_Num_Cmds;
                        o_Cmd_Idx <= 6'd0;
                        o_Err     <= 1'b0;
                        o_Busy    <= 1'b1;
                        if (i_Num_Cmds == 6'd0) begin
                            state  <= S_DONE;
                            o_Done <= 1'b1;
                        end else begin
                            state           <= S_SPI_RST;
                            o_SPI_StatusReg <= ST_RESET;
                            rst_cnt         <= 2'd0;
                        end
                    end
                end
                S_SPI_RST: begin
                    rst_cnt <= rst_cnt + 2'd1;
                    if (rst_cnt == 2'd0) begin
                        o_SPI_StatusReg <= ST_RESET;
                    end else if (rst_cnt == 2'd1) begin
                        o_SPI_StatusReg <= ST_NONE;
                    end else begin
                        state           <= S_LOAD;
                        o_SPI_StatusReg <= ST_DATA;
                        o_SPI_TxBuffer  <= cmd_byte(cur_word, '0);
                        byte_cnt        <= BW'(1);
                    end
                end
                S_LOAD: begin
                    if (byte_cnt < BYTE_LIM) begin
                        o_SPI_TxBuffer <= cmd_byte(cur_word, byte_cnt);
                        byte_cnt       <= byte_cnt + BW'(1);
                    end else begin
                        // The Data-low cycle doubles as the first SEND cycle.
                        o_SPI_StatusReg <= ST_NONE;
                        state           <= S_SEND;
                        tmo_cnt         <= '0;
                    end
                end
                S_SEND, S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (state == S_WAIT && frame_done) begin
                        if (o_Cmd_Idx == num_cmds - 6'd1) begin
                            state  <= S_DONE;
                            o_Done <= 1'b1;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state           <= S_ERR;
                        o_Err           <= 1'b1;
                        o_SPI_StatusReg <= ST_RESET;
                        rst_cnt         <= 2'd0;
                    end else if (state == S_SEND) begin
                        // Only a drop of StatusRW after Send was shown counts as acceptance.
                        if (i_SPI_StatusRW) begin
                            o_SPI_StatusReg <= ST_SEND;
                        end else if (o_SPI_StatusReg[3]) begin
                            o_SPI_StatusReg <= ST_NONE;
                            state           <= S_WAIT;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_cnt == GAP_LAST) begin
                        o_Cmd_Idx       <= idx_nxt;
                        state           <= S_LOAD;
                        o_SPI_StatusReg <= ST_DATA;
                        o_SPI_TxBuffer  <= cmd_byte(nxt_word, '0);
                        byte_cnt        <= BW'(1);
                    end
                end
                S_DONE: begin
                    o_Busy <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERR: begin
                    rst_cnt <= rst_cnt + 2'd1;
                    if (rst_cnt != 2'd0) begin
                        o_SPI_StatusReg <= ST_NONE;
                        o_Busy          <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
